// File: rtl/controle_sequenciador.sv
// controle_sequenciador: multi-cycle fetch/decode/execute/writeback sequencer
// for the 16-bit datapath. Fetches over a req/ack port, feeds the
// combinational ALU from the instruction register, and writes the
// registered result back to the register file.
//
// Build option: CTRL_MULT_WAIT_EN
//   Defined: MULT (op=5) holds EXECUTE for 1+MULT_CYCLES cycles.
//   Undefined: every opcode spends a single cycle in EXECUTE.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// FETCH     | imem_req high, waiting for imem_ack; ir loaded on ack
// DECODE    | ir fields drive RF/ALU; HALT/NOP resolved here
// EXECUTE   | ALU result and write-ok flag captured into res/wok
// WRITEBACK | one-cycle rf_we (if wok and rd!=0), pc advances
// HALT      | halted until start restarts at pc=0

module controle_sequenciador #(
  parameter int PC_W        = 8,
  parameter int MULT_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [15:0]     imem_data_i,
  output logic [2:0]      rf_ra_o,
  output logic [2:0]      rf_rb_o,
  output logic [2:0]      alu_opcode_o,
  output logic [6:0]      alu_imm_o,
  input  logic [15:0]     alu_result_i,
  input  logic            alu_wr_ok_i,
  output logic            rf_we_o,
  output logic [2:0]      rf_wa_o,
  output logic [15:0]     rf_wd_o,
  output logic [PC_W-1:0] pc_o,
  output logic            busy_o,
  output logic            halted_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [2:0] OP_MULT = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       res_q, res_d;
  logic              wok_q, wok_d;

  logic              imem_req_q;
  logic              rf_we_q;
  logic              busy_q;
  logic              halted_q;

  logic [2:0]        ir_op;
  logic [2:0]        ir_rd;

  assign ir_op = ir_q[15:13];
  assign ir_rd = ir_q[12:10];

`ifdef CTRL_MULT_WAIT_EN
  localparam int CNT_W = (MULT_CYCLES > 0) ? $clog2(MULT_CYCLES + 1) : 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
  // MULT_CYCLES only matters when the MULT wait is built in; kept so both
  // builds share one parameter list.
  logic [31:0] unused_mult_cycles;
  assign unused_mult_cycles = MULT_CYCLES;
`endif

  // Next-state and datapath-register decisions for the sequencer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    wok_d   = wok_q;
`ifdef CTRL_MULT_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_data_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_op == OP_HALT) begin
          state_d = S_HALT;
        end else if (ir_op == OP_NOP) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
`ifdef CTRL_MULT_WAIT_EN
          cnt_d   = (ir_op == OP_MULT) ? CNT_W'(MULT_CYCLES) : '0;
`endif
        end
      end
      S_EXECUTE: begin
`ifdef CTRL_MULT_WAIT_EN
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_d   = alu_result_i;
          wok_d   = alu_wr_ok_i;
          state_d = S_WRITEBACK;
        end
`else
        res_d   = alu_result_i;
        wok_d   = alu_wr_ok_i;
        state_d = S_WRITEBACK;
`endif
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath registers and registered status/strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      res_q      <= '0;
      wok_q      <= 1'b0;
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
`ifdef CTRL_MULT_WAIT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      res_q      <= res_d;
      wok_q      <= wok_d;
      imem_req_q <= (state_d == S_FETCH);
      // r0 is hard-wired: the strobe is suppressed for rd=0
      rf_we_q    <= (state_d == S_WRITEBACK) && wok_d && (ir_rd != 3'd0);
      busy_q     <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                    (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
      halted_q   <= (state_d == S_HALT);
`ifdef CTRL_MULT_WAIT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign rf_ra_o      = ir_q[9:7];
  assign rf_rb_o      = ir_q[6:4];
  assign alu_opcode_o = ir_op;
  assign alu_imm_o    = ir_q[6:0];
  assign rf_we_o      = rf_we_q;
  assign rf_wa_o      = ir_rd;
  assign rf_wd_o      = res_q;
  assign pc_o         = pc_q;
  assign busy_o       = busy_q;
  assign halted_o     = halted_q;

endmodule
